// File: rtl/sc_mips_defines.sv
// Opcode/ALU-op map shared by the control decoder and the program loader,
// plus the loader's instruction-kind and FSM state types.
package sc_mips_defines;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        KIND_R    = 3'd0,
        KIND_LW   = 3'd1,
        KIND_SW   = 3'd2,
        KIND_ADDI = 3'd3,
        KIND_BEQ  = 3'd4,
        KIND_BNE  = 3'd5,
        KIND_J    = 3'd6,
        KIND_RSVD = 3'd7
    } kind_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/sc_instr_pack.sv
// Combinational MIPS encoder: packs the fields relevant to one instruction kind
// into a 32-bit word; legal is low for the reserved kind.
module sc_instr_pack
    import sc_mips_defines::*;
(
    input  kind_t       kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (kind)
            KIND_R:    word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_LW:   word = {OP_LW,   rs, rt, imm};
            KIND_SW:   word = {OP_SW,   rs, rt, imm};
            KIND_ADDI: word = {OP_ADDI, rs, rt, imm};
            KIND_BEQ:  word = {OP_BEQ,  rs, rt, imm};
            KIND_BNE:  word = {OP_BNE,  rs, rt, imm};
            KIND_J:    word = {OP_J, target};
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sc_program_loader.sv
// Streams instruction bundles into instruction memory from word 0; one registered
// write per accepted legal bundle (1-cycle latency), in_ready low outside LOAD or when full.
module sc_program_loader
    import sc_mips_defines::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              illegal_kind,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_t      state;
    logic [31:0] packed_word;
    logic        packed_legal;
    logic        accept;

    sc_instr_pack u_pack (
        .kind   (kind_t'(in_kind)),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .funct  (in_funct),
        .imm    (in_imm),
        .target (in_target),
        .word   (packed_word),
        .legal  (packed_legal)
    );

    assign in_ready = (state == ST_LOAD) && (word_count < DEPTH_C);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_LOAD);
    assign done     = (state == ST_DONE);

    // word_count doubles as the next write address, so the two can never diverge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            illegal_kind <= 1'b0;
            word_count   <= '0;
        end else begin
            imem_we <= 1'b0;
            if (state == ST_LOAD) begin
                if (accept) begin
                    if (packed_legal) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_count[ADDR_W-1:0];
                        imem_wdata <= packed_word;
                        word_count <= word_count + ONE_C;
                    end else begin
                        illegal_kind <= 1'b1;
                    end
                    if (in_last || (packed_legal && word_count == LAST_C)) begin
                        state <= ST_DONE;
                    end
                end
            end else if (start) begin
                state        <= ST_LOAD;
                imem_addr    <= '0;
                illegal_kind <= 1'b0;
                word_count   <= '0;
            end
        end
    end

endmodule
